// File: rtl/i2c_reg_file.sv
// I2C-facing register file: ID/version, LED, switches, scratch, mailbox FIFO.
// Optional free-running timer with snapshot when REGFILE_TIMER_EN is defined.
module i2c_reg_file #(
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter logic [7:0] VERSION    = 8'h12,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       reg_wr,
  output logic [7:0] reg_rdata,
  input  logic       reg_rd,
  input  logic [7:0] sw_i,
  output logic [7:0] led_o,
  output logic [7:0] fab_data_o,
  output logic       fab_valid_o,
  input  logic       fab_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    led_q, led_d;
  logic [7:0]    scratch_q, scratch_d;
  logic [7:0]    rdcnt_q, rdcnt_d;
  logic [7:0]    sync1_q, sync2_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       cmd_wr, fifo_wr;
  logic       full, empty;
  logic       push, pop, flush;
  logic [3:0] cnt4;
  logic [7:0] status;

  assign cmd_wr  = reg_wr && (reg_addr == 8'h06);
  assign fifo_wr = reg_wr && (reg_addr == 8'h07);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign flush   = cmd_wr && reg_wdata[1];
  assign push    = fifo_wr && !full;
  // CMD pop and fabric pop together still remove a single entry
  assign pop     = ((cmd_wr && reg_wdata[0]) ||
                    (fab_valid_o && fab_ready_i)) && !empty;

  assign cnt4   = 4'(count_q);
  assign status = {full, empty, ovf_q, 1'b0, cnt4};

  assign led_o       = led_q;
  assign fab_valid_o = !empty;
  assign fab_data_o  = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    rdcnt_d   = reg_rd ? rdcnt_q + 8'd1 : rdcnt_q;
    if (reg_wr && reg_addr == 8'h02) led_d = reg_wdata;
    if (reg_wr && reg_addr == 8'h04) scratch_d = reg_wdata;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (fifo_wr && full) ovf_d = 1'b1;
    if (cmd_wr && reg_wdata[2]) ovf_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      scratch_q <= '0;
      rdcnt_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      led_q     <= led_d;
      scratch_q <= scratch_d;
      rdcnt_q   <= rdcnt_d;
      sync1_q   <= sw_i;
      sync2_q   <= sync1_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: fab_data_o is gated by empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= reg_wdata;
  end

`ifdef REGFILE_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] snap_q, snap_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    snap_d  = (cmd_wr && reg_wdata[3]) ? timer_q : snap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      timer_q <= timer_d;
      snap_q  <= snap_d;
    end
  end
`endif

  always_comb begin
    reg_rdata = 8'h00;
    case (reg_addr)
      8'h00: reg_rdata = ID_VALUE;
      8'h01: reg_rdata = VERSION;
      8'h02: reg_rdata = led_q;
      8'h03: reg_rdata = sync2_q;
      8'h04: reg_rdata = scratch_q;
      8'h05: reg_rdata = status;
      8'h07: reg_rdata = fab_data_o;
`ifdef REGFILE_TIMER_EN
      8'h08: reg_rdata = snap_q[7:0];
      8'h09: reg_rdata = snap_q[15:8];
      8'h0A: reg_rdata = snap_q[23:16];
      8'h0B: reg_rdata = snap_q[31:24];
`endif
      8'h0C: reg_rdata = rdcnt_q;
      default: reg_rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_file.sv
// Directed bench for i2c_reg_file: register map, mailbox FIFO, sync, timer.
module tb_i2c_reg_file;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_wdata = 8'h00;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_rdata;
  logic       reg_rd = 1'b0;
  logic [7:0] sw_i = 8'h3C;
  logic [7:0] led_o;
  logic [7:0] fab_data_o;
  logic       fab_valid_o;
  logic       fab_ready_i = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rdata(reg_rdata),
    .reg_rd(reg_rd), .sw_i(sw_i), .led_o(led_o),
    .fab_data_o(fab_data_o), .fab_valid_o(fab_valid_o),
    .fab_ready_i(fab_ready_i)
  );

`ifdef REGFILE_TIMER_EN
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= 32'd0;
    else tb_cyc <= tb_cyc + 32'd1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a,
                        input logic [7:0] e);
    reg_addr = a;
    #1;
    chk(tag, {24'd0, reg_rdata}, {24'd0, e});
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d,
                    input logic rdy);
    @(negedge clk);
    reg_addr = a;
    reg_wdata = d;
    reg_wr = 1'b1;
    fab_ready_i = rdy;
    @(negedge clk);
    reg_wr = 1'b0;
    fab_ready_i = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk);
    reg_rd = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0;
  endtask

`ifdef REGFILE_TIMER_EN
  logic [31:0] snap_exp;
  logic [31:0] snap_obs;
`endif

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_led", {24'd0, led_o}, 32'h00);
    chk("rst_valid", {31'd0, fab_valid_o}, 32'h0);
    chk("rst_fdata", {24'd0, fab_data_o}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("id", 8'h00, 8'hA5);
    rd_chk("version", 8'h01, 8'h12);
    rd_chk("status_rst", 8'h05, 8'h40);
    rd_chk("rdcnt_rst", 8'h0C, 8'h00);

    wr(8'h02, 8'h5A, 1'b0);
    #1;
    chk("led_o", {24'd0, led_o}, 32'h5A);
    wr(8'h04, 8'hC3, 1'b0);
    rd_chk("scratch", 8'h04, 8'hC3);
    rd_chk("led_reg", 8'h02, 8'h5A);
    wr(8'h00, 8'hFF, 1'b0);
    rd_chk("id_ro", 8'h00, 8'hA5);
    wr(8'h40, 8'h77, 1'b0);
    rd_chk("unmapped", 8'h40, 8'h00);
    wr(8'h06, 8'hF0, 1'b0);
    rd_chk("cmd_rd", 8'h06, 8'h00);

    rd_chk("sw_init", 8'h03, 8'h3C);
    @(negedge clk);
    sw_i = 8'h81;
    @(negedge clk);
    rd_chk("sw_lat1", 8'h03, 8'h3C);
    @(negedge clk);
    rd_chk("sw_lat2", 8'h03, 8'h81);

    for (int i = 1; i <= 9; i++) wr(8'h07, 8'(i), 1'b0);
    rd_chk("status_full", 8'h05, 8'hA8);
    chk("head_full", {24'd0, fab_data_o}, 32'h01);
    rd_chk("fifo_rd", 8'h07, 8'h01);
    rd_chk("fifo_nopop", 8'h05, 8'hA8);

    wr(8'h06, 8'h06, 1'b0);
    rd_chk("flush_clr", 8'h05, 8'h40);

    wr(8'h07, 8'h11, 1'b0);
    wr(8'h07, 8'h12, 1'b0);
    wr(8'h07, 8'h13, 1'b0);
    rd_chk("cnt3", 8'h05, 8'h03);
    wr(8'h06, 8'h01, 1'b1);
    rd_chk("dual_pop", 8'h05, 8'h02);
    chk("dual_head", {24'd0, fab_data_o}, 32'h12);
    wr(8'h07, 8'h14, 1'b1);
    rd_chk("push_pop", 8'h05, 8'h02);
    chk("pp_head", {24'd0, fab_data_o}, 32'h13);
    wr(8'h06, 8'h01, 1'b0);
    chk("cmdpop_head", {24'd0, fab_data_o}, 32'h14);
    for (int i = 0; i < 6; i++) wr(8'h07, 8'h15 + 8'(i), 1'b0);
    rd_chk("cnt7", 8'h05, 8'h07);

    @(negedge clk);
    fab_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #1;
    chk("wrap_last", {24'd0, fab_data_o}, 32'h1A);
    @(negedge clk);
    fab_ready_i = 1'b0;
    rd_chk("drained", 8'h05, 8'h40);
    chk("drained_vld", {31'd0, fab_valid_o}, 32'h0);

    wr(8'h06, 8'h01, 1'b0);
    rd_chk("empty_pop", 8'h05, 8'h40);
    wr(8'h07, 8'h77, 1'b0);
    rd_chk("after_ep", 8'h05, 8'h01);
    chk("after_ep_hd", {24'd0, fab_data_o}, 32'h77);

    for (int i = 0; i < 7; i++) wr(8'h07, 8'h80 + 8'(i), 1'b0);
    rd_chk("full2", 8'h05, 8'h88);
    wr(8'h07, 8'h87, 1'b1);
    rd_chk("full_popdrop", 8'h05, 8'h27);
    chk("fpd_head", {24'd0, fab_data_o}, 32'h80);
    wr(8'h06, 8'h02, 1'b0);
    rd_chk("flush_keep", 8'h05, 8'h60);
    wr(8'h06, 8'h04, 1'b0);
    rd_chk("ovf_clr", 8'h05, 8'h40);

    for (int i = 0; i < 3; i++) rd_pulse();
    rd_chk("rdcnt3", 8'h0C, 8'h03);
    for (int i = 0; i < 252; i++) rd_pulse();
    rd_chk("rdcnt_ff", 8'h0C, 8'hFF);
    rd_pulse();
    rd_chk("rdcnt_wrap", 8'h0C, 8'h00);

`ifdef REGFILE_TIMER_EN
    @(negedge clk);
    snap_exp = tb_cyc;
    reg_addr = 8'h06;
    reg_wdata = 8'h08;
    reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    repeat (100) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      reg_addr = 8'h08 + 8'(b);
      #1;
      snap_obs[b*8 +: 8] = reg_rdata;
    end
    chk("snap", snap_obs, snap_exp);
    repeat (20) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      reg_addr = 8'h08 + 8'(b);
      #1;
      snap_obs[b*8 +: 8] = reg_rdata;
    end
    chk("snap_hold", snap_obs, snap_exp);
`else
    wr(8'h06, 8'h08, 1'b0);
    repeat (100) @(negedge clk);
    rd_chk("tmr0", 8'h08, 8'h00);
    rd_chk("tmr1", 8'h09, 8'h00);
    rd_chk("tmr2", 8'h0A, 8'h00);
    rd_chk("tmr3", 8'h0B, 8'h00);
    rd_chk("tmr_status", 8'h05, 8'h40);
`endif

    wr(8'h07, 8'h55, 1'b0);
    chk("pre_rst_vld", {31'd0, fab_valid_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", {24'd0, led_o}, 32'h00);
    chk("mid_rst_vld", {31'd0, fab_valid_o}, 32'h0);
    chk("mid_rst_fd", {24'd0, fab_data_o}, 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_st", 8'h05, 8'h40);
    rd_chk("post_rst_scr", 8'h04, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_file.md
I2C_REG_FILE -- requirements
Module: i2c_reg_file

Interface
REQ-001 SHALL have parameters: ID_VALUE, default 8'hA5, value of register 0x00; VERSION, default 8'h12, value of register 0x01; FIFO_DEPTH, default 8, mailbox entries (power of two, 2..16).
REQ-002 SHALL have ports (name direction width meaning), one per line:
  clk  in  1  system clock, 100 MHz
  rst_n  in  1  reset, asynchronous, active-low
  reg_addr  in  8  register address from the I2C slave
  reg_wdata  in  8  write data
  reg_wr  in  1  one-cycle write strobe
  reg_rdata  out  8  read data, combinational from reg_addr
  reg_rd  in  1  one-cycle read strobe
  sw_i  in  8  asynchronous switch inputs
  led_o  out  8  LED drive
  fab_data_o  out  8  mailbox head entry
  fab_valid_o  out  1  mailbox not empty
  fab_ready_i  in  1  fabric consumer pop request

Function
REQ-003 SHALL decode reg_rdata combinationally from reg_addr, with no registered latency, so that data is valid in the same cycle the address is presented.
REQ-004 SHALL implement this register map: 0x00 ID RO; 0x01 VERSION RO; 0x02 LED RW; 0x03 SW RO; 0x04 SCRATCH RW; 0x05 STATUS RO; 0x06 CMD WO (reads 0x00); 0x07 FIFO_DATA (write pushes, read returns head without popping); 0x08-0x0B TIMER snapshot RO, LSB at 0x08; 0x0C RDCNT RO.
REQ-005 SHALL return 0x00 on reads of unmapped addresses and ignore writes to them and to RO registers.
REQ-006 SHALL update any RW register on the clock edge that samples reg_wr=1, so that the new value is readable in the next cycle.
REQ-007 SHALL drive led_o directly from the LED register.
REQ-008 SHALL pass sw_i through a 2-flop synchronizer before it appears in register SW (latency 2-3 cycles).
REQ-009 SHALL lay out STATUS as: [7] full, [6] empty, [5] overflow (sticky), [4] 0, [3:0] count.
REQ-010 SHALL decode CMD write bits as: [0] pop one entry; [1] flush FIFO; [2] clear overflow; [3] snapshot timer. Bits [7:4] SHALL be ignored.
REQ-011 SHALL push reg_wdata into the mailbox on a write to FIFO_DATA when count < FIFO_DEPTH; if full, SHALL drop the data and set overflow, even when a pop occurs in the same cycle.
REQ-012 SHALL drive fab_data_o from the head entry and fab_valid_o as !empty; fab_valid_o && fab_ready_i SHALL pop one entry.
REQ-013 SHALL remove exactly one entry when a CMD pop and a fabric pop occur in the same cycle.
REQ-014 SHALL treat a pop of an empty FIFO as a no-op with no pointer or count change.
REQ-015 SHALL handle a simultaneous push and pop with count < FIFO_DEPTH by leaving count unchanged and advancing both pointers; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 SHALL let flush (CMD[1]) take priority over any pop in the same write, setting count to 0 and both pointers to 0; overflow SHALL be unaffected unless CMD[2] is also set.
REQ-017 SHALL increment RDCNT by 1 on each reg_rd pulse, wrapping 0xFF to 0x00.
REQ-018 SHALL have no reg_rd side effects other than the RDCNT increment.

Reset
REQ-019 SHALL, while rst_n=0, clear LED, SCRATCH, RDCNT, the FIFO pointers, count, overflow, the timer and the snapshot to 0, and set the synchronizer flops to 0; led_o=0x00, fab_valid_o=0, and fab_data_o=0x00.
REQ-020 SHALL abandon FIFO contents when reset is asserted mid-operation, so that empty=1 in the first cycle after release.

Configuration
REQ-021 SHALL, with REGFILE_TIMER_EN defined, include a 32-bit free-running counter incremented every clk (wrapping), copy it into the 32-bit snapshot on a CMD[3] write, and return snapshot bytes at 0x08-0x0B.
REQ-022 SHALL, with REGFILE_TIMER_EN undefined, omit the counter and snapshot logic, read 0x08-0x0B as 0x00, and ignore CMD[3].

Verification
REQ-023 SHALL pass: after reset, read 0x00, 0x01, 0x05 -> 0xA5, 0x12, 0x40.
REQ-024 SHALL pass: write 0x5A to 0x02 and 0xC3 to 0x04 -> led_o=0x5A next cycle; 0x04 reads 0xC3.
REQ-025 SHALL pass: push 9 bytes 0x01..0x09 to 0x07 with depth 8 -> STATUS=0xA8; fab_data_o=0x01; the 0x09 byte is dropped.
REQ-026 SHALL pass: CMD pop and fab_ready_i=1 in the same cycle with count=3 -> count=2 and head advances by exactly one.
REQ-027 SHALL pass: write CMD 0x06 with FIFO full and overflow set -> STATUS=0x40.
REQ-028 SHALL pass: with REGFILE_TIMER_EN defined, CMD 0x08, then wait 100 cycles and read 0x08-0x0B -> values remain constant and equal the counter value at the snapshot edge; with the macro undefined, reads return 0x00.
